// File: rtl/uart_time_sender_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_time_sender_if
// Purpose  : Byte handshake between the time sender and the UART transmitter.
// Signals  : o_tx_start  1  one-cycle start pulse (sender -> transmitter)
//            o_tx_data   8  byte to transmit, held until the byte completes
//            i_tx_busy   1  transmitter busy (transmitter -> sender)
//            i_tx_done   1  one-cycle byte-done pulse (transmitter -> sender)
// Modports : master = sender side, slave = transmitter side
// Revision : 1.0 - initial release
// ============================================================================
interface uart_time_sender_if;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_tx_done;

  modport master (
    output o_tx_start,
    output o_tx_data,
    input  i_tx_busy,
    input  i_tx_done
  );

  modport slave (
    input  o_tx_start,
    input  o_tx_data,
    output i_tx_busy,
    output i_tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_time_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_time_sender
// Purpose  : Snapshots a time value on request and streams it to a UART
//            transmitter as ASCII "HH:MM:SS.CC", optionally followed by CR LF.
// Params   : CRLF     1 = append 0x0D 0x0A (13 bytes), 0 = 11 bytes
// Ports    : clk      system clock
//            rst      synchronous active-high reset
//            i_send   send request, only honoured while idle
//            i_hour   hours (5 bit), i_min / i_sec minutes/seconds (6 bit),
//            i_cs     centiseconds (7 bit), all binary
//            tx       transmitter handshake (master side)
//            o_busy   message in progress
//            o_done   one-cycle pulse after the last byte completes
// Revision : 1.0 - initial release
// ============================================================================
module uart_time_sender #(
  parameter bit CRLF = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_send,
  input  logic [4:0]                 i_hour,
  input  logic [5:0]                 i_min,
  input  logic [5:0]                 i_sec,
  input  logic [6:0]                 i_cs,
  uart_time_sender_if.master         tx,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int         LEN  = CRLF ? 13 : 11;
  localparam logic [3:0] LAST = 4'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic [4:0] hour_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic [6:0] cs_q;
  logic [7:0] char_sel;

  // Fields wider than two decimal digits (minutes/seconds up to 63 are fine,
  // centiseconds up to 127 are not) are clamped so they always print as "99".
  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] tens_ch(input logic [6:0] v);
    logic [6:0] c;
    c = clamp99(v);
    return 8'h30 + 8'(c / 7'd10);
  endfunction

  function automatic logic [7:0] ones_ch(input logic [6:0] v);
    logic [6:0] c;
    c = clamp99(v);
    return 8'h30 + 8'(c % 7'd10);
  endfunction

  // Character for the current index, always derived from the snapshot.
  always_comb begin
    char_sel = 8'h00;
    case (idx)
      4'd0:    char_sel = tens_ch({2'b00, hour_q});
      4'd1:    char_sel = ones_ch({2'b00, hour_q});
      4'd2:    char_sel = 8'h3A;
      4'd3:    char_sel = tens_ch({1'b0, min_q});
      4'd4:    char_sel = ones_ch({1'b0, min_q});
      4'd5:    char_sel = 8'h3A;
      4'd6:    char_sel = tens_ch({1'b0, sec_q});
      4'd7:    char_sel = ones_ch({1'b0, sec_q});
      4'd8:    char_sel = 8'h2E;
      4'd9:    char_sel = tens_ch(cs_q);
      4'd10:   char_sel = ones_ch(cs_q);
      4'd11:   char_sel = 8'h0D;
      4'd12:   char_sel = 8'h0A;
      default: char_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 4'd0;
      hour_q        <= 5'd0;
      min_q         <= 6'd0;
      sec_q         <= 6'd0;
      cs_q          <= 7'd0;
      tx.o_tx_start <= 1'b0;
      tx.o_tx_data  <= 8'h00;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      // Pulses default low so each is high for exactly one cycle.
      tx.o_tx_start <= 1'b0;
      o_done        <= 1'b0;
      case (state)
        IDLE: begin
          if (i_send) begin
            hour_q <= i_hour;
            min_q  <= i_min;
            sec_q  <= i_sec;
            cs_q   <= i_cs;
            idx    <= 4'd0;
            o_busy <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (!tx.i_tx_busy) begin
            tx.o_tx_start <= 1'b1;
            tx.o_tx_data  <= char_sel;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // o_tx_data is left untouched here: the transmitter samples it
          // throughout the data phase.
          if (tx.i_tx_done) begin
            if (idx == LAST) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= START;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_time_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_time_sender
// Purpose  : Self-checking bench for uart_time_sender. Two instances (CRLF=0
//            and CRLF=1) share the time inputs; sel picks which one the
//            transmitter model and byte scoreboard are attached to.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_time_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic       sel = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic [6:0] cs = '0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  logic busy0, done0, busy1, done1;
  logic send0, send1;
  logic mon_start, mon_busy, mon_done;
  logic [7:0] mon_data;

  always #5 clk = ~clk;

  uart_time_sender_if bus0 ();
  uart_time_sender_if bus1 ();

  assign send0 = send & ~sel;
  assign send1 = send & sel;
  assign bus0.i_tx_busy = ~sel & m_busy;
  assign bus0.i_tx_done = ~sel & m_done;
  assign bus1.i_tx_busy = sel & m_busy;
  assign bus1.i_tx_done = sel & m_done;

  assign mon_start = sel ? bus1.o_tx_start : bus0.o_tx_start;
  assign mon_data  = sel ? bus1.o_tx_data  : bus0.o_tx_data;
  assign mon_busy  = sel ? busy1 : busy0;
  assign mon_done  = sel ? done1 : done0;

  uart_time_sender #(.CRLF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_send(send0),
    .i_hour(hour), .i_min(min), .i_sec(sec), .i_cs(cs),
    .tx(bus0), .o_busy(busy0), .o_done(done0)
  );

  uart_time_sender #(.CRLF(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_send(send1),
    .i_hour(hour), .i_min(min), .i_sec(sec), .i_cs(cs),
    .tx(bus1), .o_busy(busy1), .o_done(done1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_cnt = 0;
  int         done_cnt = 0;
  int         exp_len = 0;
  int         stall_req = 0;
  int         gap_cnt = 0;
  int         gap_last = 0;
  logic       gap_run = 1'b0;
  int         lat_cnt = 0;
  logic [7:0] held = '0;
  logic       prev_start = 1'b0;
  logic       prev_done = 1'b0;

  // Transmitter model and scoreboard monitor, acting on the falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; lat_cnt = 0;
      prev_start = 1'b0; prev_done = 1'b0; gap_run = 1'b0;
    end else begin
      m_done = 1'b0;
      if (gap_run) gap_cnt++;
      if (mon_start) begin
        start_cnt++;
        checks++;
        if (prev_start || m_busy) begin
          errors++;
          $display("FAIL start_legal: start=1 with prev_start=%0b tx_busy=%0b, required both 0", prev_start, m_busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got start with data %02h, required no start", mon_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (mon_data !== exp_b) begin
            errors++;
            $display("FAIL byte%0d: got %02h required %02h", start_cnt - 1, mon_data, exp_b);
          end
        end
        if (gap_run) begin gap_last = gap_cnt; gap_run = 1'b0; end
        held = mon_data; m_busy = 1'b1; lat_cnt = 10;
      end else if (m_busy) begin
        if (lat_cnt > 0) begin
          checks++;
          if (mon_data !== held) begin
            errors++;
            $display("FAIL data_stable: got %02h required %02h", mon_data, held);
          end
          lat_cnt--;
          if (lat_cnt == 0) begin
            m_done = 1'b1;
            if (stall_req > 0) begin gap_run = 1'b1; gap_cnt = 0; end
            else m_busy = 1'b0;
          end
        end else begin
          stall_req--;
          if (stall_req <= 0) begin stall_req = 0; m_busy = 1'b0; end
        end
      end
      if (mon_done) begin
        done_cnt++;
        checks++;
        if (mon_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_done: got %0b required 1", mon_busy);
        end
        checks++;
        if (exp_q.size() != 0 || start_cnt != exp_len) begin
          errors++;
          $display("FAIL msg_len: got starts=%0d pending=%0d required starts=%0d pending=0", start_cnt, exp_q.size(), exp_len);
        end
      end
      if (prev_done) begin
        checks++;
        if (mon_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_done: got %0b required 0", mon_busy);
        end
      end
      prev_start = mon_start;
      prev_done  = mon_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] asc(input int v);
    return 8'(48 + v);
  endfunction

  task automatic push_expect(input int h, input int m, input int s, input int c, input bit crlf);
    int v[4];
    v[0] = h; v[1] = m; v[2] = s; v[3] = c;
    for (int k = 0; k < 4; k++) begin
      if (v[k] > 99) v[k] = 99;
      exp_q.push_back(asc(v[k] / 10));
      exp_q.push_back(asc(v[k] % 10));
      if (k == 0 || k == 1) exp_q.push_back(8'h3A);
      if (k == 2) exp_q.push_back(8'h2E);
    end
    if (crlf) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
    exp_len = crlf ? 13 : 11;
  endtask

  task automatic send_msg(input int h, input int m, input int s, input int c);
    hour = 5'(h); min = 6'(m); sec = 6'(s); cs = 7'(c);
    push_expect(h, m, s, c, sel);
    start_cnt = 0;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL done_pulse: got %0d dones required %0d", done_cnt - d0, 1);
    end
    tick(); tick();
  endtask

  task automatic run_message(input logic s, input int h, input int m, input int se, input int c);
    int d0;
    sel = s;
    d0 = done_cnt;
    send_msg(h, m, se, c);
    wait_done(d0);
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (start_cnt >= n) break;
      tick();
    end
    checks++;
    if (start_cnt < n) begin
      errors++;
      $display("FAIL start_timeout: got %0d starts required %0d", start_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks += 8;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b%0b required 00", busy0, busy1); end
    if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b%0b required 00", done0, done1); end
    if (bus0.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start0: got %0b required 0", bus0.o_tx_start); end
    if (bus1.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start1: got %0b required 0", bus1.o_tx_start); end
    if (bus0.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data0: got %02h required 00", bus0.o_tx_data); end
    if (bus1.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data1: got %02h required 00", bus1.o_tx_data); end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %0b required 0", busy0); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %0b required 0", busy1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_crlf();
    run_message(1'b1, 12, 34, 56, 78);
  endtask

  task automatic test_no_crlf();
    run_message(1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    run_message(1'b0, 31, 63, 63, 127);
  endtask

  task automatic test_snapshot();
    int d0;
    sel = 1'b1;
    d0 = done_cnt;
    send_msg(1, 2, 3, 4);
    wait_starts(4);
    hour = 5'd23; min = 6'd59; sec = 6'd58; cs = 7'd99;
    send = 1'b1;
    tick();
    send = 1'b0;
    wait_done(d0);
    repeat (40) tick();
    checks += 2;
    if (mon_busy !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL no_second_msg: got busy=%0b dones=%0d required busy=0 dones=1", mon_busy, done_cnt - d0);
    end
    if (start_cnt != 13) begin
      errors++;
      $display("FAIL snapshot_starts: got %0d required 13", start_cnt);
    end
  endtask

  task automatic test_busy_stall();
    stall_req = 20;
    gap_last = 0;
    run_message(1'b0, 9, 8, 7, 6);
    checks++;
    if (gap_last < 21 || stall_req != 0) begin
      errors++;
      $display("FAIL stall_gap: got gap=%0d stall_left=%0d required gap>=21 stall_left=0", gap_last, stall_req);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    sel = 1'b1;
    d0 = done_cnt;
    send_msg(12, 34, 56, 78);
    wait_starts(6);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks += 4;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b required 0", busy1); end
    if (bus1.o_tx_start !== 1'b0) begin errors++; $display("FAIL abort_start: got %0b required 0", bus1.o_tx_start); end
    if (bus1.o_tx_data !== 8'h00) begin errors++; $display("FAIL abort_data: got %02h required 00", bus1.o_tx_data); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b required 0", done1); end
    rst = 1'b0;
    exp_q.delete();
    repeat (30) tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones required 0", done_cnt - d0);
    end
    run_message(1'b1, 21, 5, 9, 40);
  endtask

  initial begin
    test_reset();
    test_crlf();
    test_no_crlf();
    test_saturation();
    test_snapshot();
    test_busy_stall();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_time_sender.md
Name: uart_time_sender

Overview:
- Sequencer that sits in front of the UART transmitter in the stopwatch/watch design.
- On a send request it snapshots the current time fields and converts them to ASCII "HH:MM:SS.CC" (optionally followed by CR LF).
- It feeds the message to the transmitter one byte at a time using start/busy/done handshakes.
- One instance serves the display path; the time source is either the stopwatch or the watch, selected upstream.

Parameters:
- CRLF, 1, 1 = append 0x0D 0x0A (message length 13); 0 = no terminator (message length 11).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_send  input  1  send request; sampled only in IDLE
- i_hour  input  5  hours, binary
- i_min  input  6  minutes, binary
- i_sec  input  6  seconds, binary
- i_cs  input  7  centiseconds, binary
- i_tx_busy  input  1  transmitter busy
- i_tx_done  input  1  transmitter one-cycle byte-done pulse
- o_tx_start  output  1  one-cycle start pulse to transmitter
- o_tx_data  output  8  byte to transmit; registered
- o_busy  output  1  message in progress
- o_done  output  1  one-cycle pulse after the last byte completes

Behaviour:
- Reset and clocking:
  - One clock domain. Reset is synchronous and active-high.
  - Reset values: o_tx_start=0, o_tx_data=0x00, o_busy=0, o_done=0, state=IDLE, idx=0.
  - Snapshot registers reset to 0.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - o_busy=0.
  - When i_send=1: latch all four fields into snapshot registers, set idx=0, go to START.
  - o_busy reads 1 from the next cycle onward.
- START:
  - If i_tx_busy=0: assert o_tx_start for exactly one cycle, with o_tx_data = char(idx) in that same cycle, then go to WAIT.
  - If i_tx_busy=1: stay in START with o_tx_start=0.
- WAIT:
  - o_tx_data is held constant, because the transmitter reads din throughout the data phase.
  - On i_tx_done=1: if idx = LEN-1, go to DONE; otherwise idx <= idx+1 and go to START.
- DONE:
  - o_done=1 for one cycle, o_busy stays 1 in that cycle, then go to IDLE.
  - The earliest new request is accepted one cycle after DONE.
- Byte order (char(idx)), by idx:
  - 0: H tens, 1: H ones, 2: ':'
  - 3: M tens, 4: M ones, 5: ':'
  - 6: S tens, 7: S ones, 8: '.'
  - 9: C tens, 10: C ones
  - 11: 0x0D, 12: 0x0A (present only when CRLF=1)
- ASCII conversion:
  - digit = 0x30 + value.
  - tens = v/10 and ones = v%10, computed on the snapshot, never on live inputs.
- Saturation: each field is clamped to 99 before conversion, so i_cs=127 is sent as "99". Hour 0–31 needs no clamp.
- Snapshot rule: live inputs changing mid-message have no effect on the bytes sent.
- i_send while busy: ignored, not queued.
- i_tx_done outside WAIT: ignored.
- Reset in any state: returns to IDLE with all outputs at reset values in the next cycle. The message is aborted and no o_done is issued.
- Bus behaviour: o_tx_start is never asserted two cycles in a row. Per message there are exactly LEN start pulses and exactly one o_done pulse.

Test Plan:
- 12:34:56.78, CRLF=1, i_send pulse, transmitter model gives done 10 cycles after each start → bytes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x2E 0x37 0x38 0x0D 0x0A; 13 starts; one o_done; o_busy falls the cycle after o_done.
- CRLF=0, time 00:00:00.00 → 11 bytes: 0x30 0x30 0x3A 0x30 0x30 0x3A 0x30 0x30 0x2E 0x30 0x30; o_done after the 11th done.
- Saturation: hour=31, min=63, sec=63, cs=127 → "31:63:63.99", i.e. 0x33 0x31 0x3A 0x36 0x33 0x3A 0x36 0x33 0x2E 0x39 0x39.
- Snapshot and ignored requests: change all inputs and pulse i_send after byte 3 → remaining bytes match the original snapshot; no second message starts.
- i_tx_busy held high 20 cycles on entry to START → o_tx_start stays 0 until busy falls, then pulses once; o_tx_data is stable from the start pulse until done.
- rst asserted during WAIT of byte 5 → next cycle o_busy=0, o_tx_start=0, o_tx_data=0x00, no o_done; a subsequent i_send sends a full correct message from byte 0.
